// File: rtl/led_breathe_sequencer.sv
// PWM LED breathing sequencer: ramp up, hold high, ramp down, hold low, repeated
// under a start/stop/done handshake. Every phase change lands on a PWM period boundary.
module led_breathe_sequencer #(
  parameter int PRESCALE     = 39062,
  parameter int STEP_PERIODS = 4,
  parameter int HOLD_PERIODS = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] duty_max,
  input  logic [7:0] repeat_cnt,
  output logic       led,
  output logic [7:0] duty,
  output logic       busy,
  output logic       done,
  output logic       period_tick
);

  localparam int SUB_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam int HOLD_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(PRESCALE - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_PERIODS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_HOLD_HIGH = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_HOLD_LOW  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [7:0]        slot_q, slot_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [7:0]        duty_q, duty_d;
  logic [7:0]        dmax_q, dmax_d;
  logic [7:0]        rep_q, rep_d;
  logic              led_q, led_d;
  logic              done_q, done_d;

  logic tick;
  logic step_end;
  logic hold_end;

  assign busy        = (state_q != S_IDLE);
  assign tick        = busy && (slot_q == 8'hFF) && (sub_q == SUB_LAST);
  assign step_end    = tick && (step_q == STEP_LAST);
  assign hold_end    = tick && (hold_q == HOLD_LAST);
  assign period_tick = tick;
  assign led         = led_q;
  assign duty        = duty_q;
  assign done        = done_q;

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    slot_d  = slot_q;
    step_d  = step_q;
    hold_d  = hold_q;
    duty_d  = duty_q;
    dmax_d  = dmax_q;
    rep_d   = rep_q;
    done_d  = 1'b0;

    if (busy) begin
      if (sub_q == SUB_LAST) begin
        sub_d  = '0;
        slot_d = slot_q + 8'd1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_RAMP_UP;
          dmax_d  = duty_max;
          rep_d   = repeat_cnt;
          duty_d  = 8'd0;
        end
      end
      S_RAMP_UP: begin
        if (tick) step_d = step_end ? '0 : step_q + 1'b1;
        if (step_end) begin
          if (duty_q < dmax_q) duty_d = duty_q + 8'd1;
          else                 state_d = S_HOLD_HIGH;
        end
      end
      S_HOLD_HIGH: begin
        if (tick) hold_d = hold_q + 1'b1;
        if (hold_end) state_d = S_RAMP_DOWN;
      end
      S_RAMP_DOWN: begin
        if (tick) step_d = step_end ? '0 : step_q + 1'b1;
        if (step_end) begin
          if (duty_q != 8'd0) duty_d = duty_q - 8'd1;
          else                state_d = S_HOLD_LOW;
        end
      end
      S_HOLD_LOW: begin
        if (tick) hold_d = hold_q + 1'b1;
        if (hold_end) begin
          if (rep_q == 8'd0) begin
            state_d = S_RAMP_UP;
          end else if (rep_q == 8'd1) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            rep_d   = rep_q - 8'd1;
            state_d = S_RAMP_UP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over a completion landing on the same edge.
    if (busy && stop) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end

    if (state_d != state_q) begin
      step_d = '0;
      hold_d = '0;
    end

    if (state_d == S_IDLE) begin
      sub_d  = '0;
      slot_d = 8'd0;
      step_d = '0;
      hold_d = '0;
      duty_d = 8'd0;
    end

    // Compare uses this cycle's slot/duty, so led trails the slot counter by one clk.
    led_d = (state_d != S_IDLE) && (slot_q < duty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sub_q   <= '0;
      slot_q  <= 8'd0;
      step_q  <= '0;
      hold_q  <= '0;
      duty_q  <= 8'd0;
      dmax_q  <= 8'd0;
      rep_q   <= 8'd0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      slot_q  <= slot_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      duty_q  <= duty_d;
      dmax_q  <= dmax_d;
      rep_q   <= rep_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_led_breathe_sequencer.sv
// Bench for led_breathe_sequencer: two instances with different timing parameters share
// the stimulus; each is compared every clk against a time-based arithmetic model.
module tb_led_breathe_sequencer;

  localparam int A_PS = 1, A_ST = 1, A_HD = 2;
  localparam int B_PS = 2, B_ST = 2, B_HD = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] duty_max = 8'd0;
  logic [7:0] repeat_cnt = 8'd0;

  logic       led_a, busy_a, done_a, tick_a;
  logic [7:0] duty_a;
  logic       led_b, busy_b, done_b, tick_b;
  logic [7:0] duty_b;

  int n_cmp = 0;
  int n_err = 0;
  int dcnt_a = 0;
  int dcnt_b = 0;

  // Model state per instance: active flag, clks since the accepted start edge, latched inputs.
  int     ps[2], st[2], hd[2];
  bit     act[2];
  longint t[2];
  int     dm[2], rp[2];
  bit     done_e[2];

  always #5 clk = ~clk;

  led_breathe_sequencer #(.PRESCALE(A_PS), .STEP_PERIODS(A_ST), .HOLD_PERIODS(A_HD)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .duty_max(duty_max), .repeat_cnt(repeat_cnt),
    .led(led_a), .duty(duty_a), .busy(busy_a), .done(done_a), .period_tick(tick_a)
  );

  led_breathe_sequencer #(.PRESCALE(B_PS), .STEP_PERIODS(B_ST), .HOLD_PERIODS(B_HD)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .duty_max(duty_max), .repeat_cnt(repeat_cnt),
    .led(led_b), .duty(duty_b), .busy(busy_b), .done(done_b), .period_tick(tick_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint per(input int i);
    return 64'(256 * ps[i]);
  endfunction

  function automatic longint cyc_periods(input int i);
    return 64'((2 * dm[i] + 2) * st[i] + 2 * hd[i]);
  endfunction

  function automatic longint slot_at(input int i, input longint tt);
    return (tt % per(i)) / ps[i];
  endfunction

  function automatic longint duty_at(input int i, input longint tt);
    longint m, r;
    m = (tt / per(i)) % cyc_periods(i);
    r = 64'((dm[i] + 1) * st[i]);
    if (m < r)                  return m / st[i];
    else if (m < r + hd[i])     return 64'(dm[i]);
    else if (m < 2 * r + hd[i]) return dm[i] - (m - r - hd[i]) / st[i];
    else                        return 0;
  endfunction

  task automatic model_edge(input int i);
    longint endt;
    done_e[i] = 1'b0;
    if (rst) begin
      act[i] = 1'b0;
    end else if (act[i]) begin
      t[i]++;
      endt = 64'(rp[i]) * cyc_periods(i) * per(i);
      if (stop) act[i] = 1'b0;
      else if (rp[i] != 0 && t[i] == endt) begin
        act[i]    = 1'b0;
        done_e[i] = 1'b1;
      end
    end else if (start && !stop) begin
      act[i] = 1'b1;
      t[i]   = 0;
      dm[i]  = int'(duty_max);
      rp[i]  = int'(repeat_cnt);
    end
  endtask

  task automatic check_dut(input int i, input logic g_led, input logic [7:0] g_duty,
                           input logic g_busy, input logic g_tick, input logic g_done);
    logic       e_led, e_busy, e_tick;
    logic [7:0] e_duty;
    e_led = 1'b0; e_busy = 1'b0; e_tick = 1'b0; e_duty = 8'd0;
    if (act[i]) begin
      e_busy = 1'b1;
      e_duty = 8'(duty_at(i, t[i]));
      e_tick = ((t[i] % per(i)) == per(i) - 1);
      e_led  = (t[i] > 0) && (slot_at(i, t[i] - 1) < duty_at(i, t[i] - 1));
    end
    chk($sformatf("u%0d.busy t=%0d", i, t[i]), g_busy, e_busy);
    chk($sformatf("u%0d.duty t=%0d", i, t[i]), g_duty, e_duty);
    chk($sformatf("u%0d.led t=%0d", i, t[i]), g_led, e_led);
    chk($sformatf("u%0d.period_tick t=%0d", i, t[i]), g_tick, e_tick);
    chk($sformatf("u%0d.done t=%0d", i, t[i]), g_done, done_e[i]);
  endtask

  task automatic tick_clk();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    @(negedge clk);
    check_dut(0, led_a, duty_a, busy_a, tick_a, done_a);
    check_dut(1, led_b, duty_b, busy_b, tick_b, done_b);
    if (done_a) dcnt_a++;
    if (done_b) dcnt_b++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick_clk();
  endtask

  task automatic run_idle(input int budget);
    int k;
    k = 0;
    while ((act[0] || act[1]) && k < budget) begin
      tick_clk();
      k++;
    end
    chk("idle_reached", {31'd0, act[0] | act[1]}, 32'd0);
  endtask

  task automatic pulse_start(input logic [7:0] d, input logic [7:0] r);
    duty_max   = d;
    repeat_cnt = r;
    start      = 1'b1;
    tick_clk();
    start      = 1'b0;
    duty_max   = 8'($urandom_range(0, 255));
    repeat_cnt = 8'($urandom_range(0, 255));
  endtask

  initial begin
    int cyc_a;
    logic [7:0] d;
    ps[0] = A_PS; st[0] = A_ST; hd[0] = A_HD;
    ps[1] = B_PS; st[1] = B_ST; hd[1] = B_HD;
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; t[i] = 0; dm[i] = 0; rp[i] = 0; done_e[i] = 1'b0;
    end

    // Reset, then a long idle stretch.
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(1000);

    // Single cycle, dmax=3: done 12 periods after the start edge on instance A.
    dcnt_a = 0; dcnt_b = 0;
    pulse_start(8'd3, 8'd1);
    run(3071);
    chk("single_busy_before_done", {31'd0, busy_a}, 32'd1);
    tick_clk();
    chk("single_done_edge", {31'd0, done_a}, 32'd1);
    chk("single_busy_low_at_done", {31'd0, busy_a}, 32'd0);
    run_idle(20000);
    chk("single_done_cnt_a", dcnt_a, 1);
    chk("single_done_cnt_b", dcnt_b, 1);

    // start and stop together in IDLE.
    start = 1'b1; stop = 1'b1;
    run(3);
    start = 1'b0; stop = 1'b0;
    run(2);
    chk("start_stop_idle", {31'd0, busy_a | busy_b}, 32'd0);

    // Three repeats with a random peak.
    dcnt_a = 0; dcnt_b = 0;
    pulse_start(8'($urandom_range(0, 2)), 8'd3);
    run_idle(30000);
    chk("rep3_done_cnt_a", dcnt_a, 1);
    chk("rep3_done_cnt_b", dcnt_b, 1);

    // Random run with a start/new duty_max attempt while busy.
    dcnt_a = 0; dcnt_b = 0;
    pulse_start(8'($urandom_range(0, 3)), 8'd1);
    run($urandom_range(50, 400));
    start = 1'b1; duty_max = 8'd200; repeat_cnt = 8'd9;
    run(3);
    start = 1'b0;
    run_idle(20000);
    chk("rand_done_cnt_a", dcnt_a, 1);

    // Infinite mode: still cycling after five cycles, then stop.
    dcnt_a = 0;
    d = 8'($urandom_range(0, 2));
    cyc_a = ((2 * int'(d) + 2) * A_ST + 2 * A_HD) * 256 * A_PS;
    pulse_start(d, 8'd0);
    run(5 * cyc_a + 100);
    chk("inf_busy", {31'd0, busy_a}, 32'd1);
    chk("inf_no_done", dcnt_a, 0);
    stop = 1'b1;
    tick_clk();
    stop = 1'b0;
    chk("inf_stop_busy", {31'd0, busy_a}, 32'd0);
    chk("inf_stop_led", {31'd0, led_a}, 32'd0);
    run(5);

    // Stop in the middle of RAMP_DOWN (A: periods 6..9 for dmax=3).
    dcnt_a = 0;
    pulse_start(8'd3, 8'd1);
    run(6 * 256 + 300);
    chk("rd_duty_before_stop", {24'd0, duty_a}, 32'd2);
    stop = 1'b1;
    tick_clk();
    stop = 1'b0;
    run(10);
    chk("rd_stop_no_done", dcnt_a, 0);

    // Stop sampled on the final HOLD_LOW period_tick edge (A: dmax=1, 8 periods).
    dcnt_a = 0;
    pulse_start(8'd1, 8'd1);
    run(2047);
    chk("final_tick_seen", {31'd0, tick_a}, 32'd1);
    stop = 1'b1;
    tick_clk();
    stop = 1'b0;
    run(5);
    chk("final_stop_no_done", dcnt_a, 0);

    // Reset during HOLD_HIGH (A: periods 3..4 for dmax=2), then a fresh run.
    pulse_start(8'd2, 8'd1);
    run(900);
    chk("hh_duty_before_rst", {24'd0, duty_a}, 32'd2);
    rst = 1'b1;
    tick_clk();
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_duty", {24'd0, duty_a}, 32'd0);
    dcnt_a = 0;
    pulse_start(8'($urandom_range(0, 3)), 8'd1);
    run_idle(20000);
    chk("post_rst_done_cnt_a", dcnt_a, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
